// File: rtl/ttl_pkg.sv
// Shared constants for the TTL latch-bank models.
package ttl_pkg;

  // Capture behaviour selectors for the MODE parameter
  localparam int LATCH_TRANSPARENT = 0;
  localparam int LATCH_EDGE        = 1;

  // Deepest propagation-delay pipeline a channel may be built with
  localparam int DLY_CYC_MAX = 15;

  // True when a MODE / DLY_CYC pair describes a buildable channel
  function automatic bit params_ok(input int mode, input int dly);
    return ((mode == LATCH_TRANSPARENT) || (mode == LATCH_EDGE)) &&
           (dly >= 0) && (dly <= DLY_CYC_MAX);
  endfunction

endpackage

// File: rtl/ttl_latch_bank_chan.sv
// One 74LS373/374-style channel: hold register, pin edge detect and a
// delay line carrying {output-enable, data} so both reach q together.
// Optional macro TTL_LATCH_BANK_TRISTATE_EN: disabled outputs drive 'z.
module ttl_latch_bank_chan
  import ttl_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MODE      = LATCH_TRANSPARENT,
  parameter int   DLY_CYC   = 2,
  parameter logic FLOAT_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             oc_n,
  input  logic             c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_drive
);

  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] hold_next;
  logic             c_prev;
  logic             capture;

  // Stage 0 is the capture stage; stages 1..DLY_CYC add the modelled
  // propagation delay, so the output stage sits DLY_CYC+1 edges after d.
  logic             pipe_oe   [DLY_CYC+1];
  logic [WIDTH-1:0] pipe_data [DLY_CYC+1];

  // Decide whether this time step captures d (level in 373 mode, rising pin in 374 mode)
  always_comb begin
    capture   = 1'b0;
    hold_next = hold;
    if (cen) begin
      if (MODE == LATCH_EDGE) begin
        capture = c & ~c_prev;
      end else begin
        capture = c;
      end
    end
    if (capture) begin
      hold_next = d;
    end
  end

  // Hold register, pin history and delay line all advance only on cen; reset wins
  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= '0;
      c_prev <= 1'b1;
      for (int i = 0; i <= DLY_CYC; i++) begin
        pipe_oe[i]   <= 1'b0;
        pipe_data[i] <= '0;
      end
    end else if (cen) begin
      hold         <= hold_next;
      c_prev       <= c;
      pipe_oe[0]   <= ~oc_n;
      pipe_data[0] <= hold_next;
      for (int i = 1; i <= DLY_CYC; i++) begin
        pipe_oe[i]   <= pipe_oe[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign q_drive = pipe_oe[DLY_CYC];

`ifdef TTL_LATCH_BANK_TRISTATE_EN
  assign q = q_drive ? pipe_data[DLY_CYC] : {WIDTH{1'bz}};
`else
  assign q = q_drive ? pipe_data[DLY_CYC] : {WIDTH{FLOAT_VAL}};
`endif

endmodule

// File: rtl/ttl_latch_bank_sync.sv
// Bank of CHANNELS independent octal latches/registers with modelled delay.
// Optional macro TTL_LATCH_BANK_TRISTATE_EN: disabled outputs drive 'z
// instead of the FLOAT_VAL pattern.
module ttl_latch_bank_sync
  import ttl_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   CHANNELS  = 2,
  parameter int   MODE      = LATCH_TRANSPARENT,
  parameter int   DLY_CYC   = 2,
  parameter logic FLOAT_VAL = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic [CHANNELS-1:0]       oc_n,
  input  logic [CHANNELS-1:0]       c,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       q_drive
);

  // Refuse to build a channel with an unsupported mode or delay depth
  if (!params_ok(MODE, DLY_CYC)) begin : g_bad_params
    $fatal(1, "ttl_latch_bank_sync: MODE must be 0 or 1 and DLY_CYC 0..15");
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    ttl_latch_bank_chan #(
      .WIDTH    (WIDTH),
      .MODE     (MODE),
      .DLY_CYC  (DLY_CYC),
      .FLOAT_VAL(FLOAT_VAL)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .cen    (cen),
      .oc_n   (oc_n[ch]),
      .c      (c[ch]),
      .d      (d[ch*WIDTH +: WIDTH]),
      .q      (q[ch*WIDTH +: WIDTH]),
      .q_drive(q_drive[ch])
    );
  end

endmodule

// File: tb/tb_ttl_latch_bank_sync.sv
// Self-checking bench for ttl_latch_bank_sync: three builds (373 delay 2,
// 374 delay 3, 374 delay 0) share one stimulus stream and are compared
// every cycle against a history-lookup model of the device.
module tb_ttl_latch_bank_sync;

  localparam int NDUT = 3;

  logic        clk;
  logic        rst;
  logic        cen;
  logic [1:0]  oc_n;
  logic [1:0]  c;
  logic [15:0] d;

  logic [15:0] q0, q1, q2;
  logic [1:0]  qd0, qd1, qd2;
  logic [15:0] qa [NDUT];
  logic [1:0]  da [NDUT];

  int tests;
  int failures;

  // Model state: per build and channel, the held byte, the last sampled
  // pin, and a log of {enabled, held byte} after every cen edge.
  logic [7:0]  m_hold  [NDUT][2];
  logic        m_cprev [NDUT][2];
  logic [8:0]  m_hist  [NDUT][2][32];
  int unsigned m_count [NDUT];

  ttl_latch_bank_sync #(.WIDTH(8), .CHANNELS(2), .MODE(0), .DLY_CYC(2), .FLOAT_VAL(1'b1)) dut0 (
    .clk(clk), .rst(rst), .cen(cen), .oc_n(oc_n), .c(c), .d(d), .q(q0), .q_drive(qd0));
  ttl_latch_bank_sync #(.WIDTH(8), .CHANNELS(2), .MODE(1), .DLY_CYC(3), .FLOAT_VAL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cen(cen), .oc_n(oc_n), .c(c), .d(d), .q(q1), .q_drive(qd1));
  ttl_latch_bank_sync #(.WIDTH(8), .CHANNELS(2), .MODE(1), .DLY_CYC(0), .FLOAT_VAL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .cen(cen), .oc_n(oc_n), .c(c), .d(d), .q(q2), .q_drive(qd2));

  assign qa[0] = q0;
  assign qa[1] = q1;
  assign qa[2] = q2;
  assign da[0] = qd0;
  assign da[1] = qd1;
  assign da[2] = qd2;

  // Free-running system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int modeOf(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int dlyOf(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic modelStep();
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        m_count[i] = 0;
        for (int ch = 0; ch < 2; ch++) begin
          m_hold[i][ch]  = 8'h00;
          m_cprev[i][ch] = 1'b1;
        end
      end else if (cen) begin
        m_count[i]++;
        for (int ch = 0; ch < 2; ch++) begin
          if (modeOf(i) == 0 ? c[ch] : (c[ch] && !m_cprev[i][ch]))
            m_hold[i][ch] = d[ch*8 +: 8];
          m_cprev[i][ch] = c[ch];
          m_hist[i][ch][m_count[i] % 32] = {~oc_n[ch], m_hold[i][ch]};
        end
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, and check on the falling edge
  task automatic applyStimulus(input logic r, input logic ce, input logic [1:0] oc,
                               input logic [1:0] cc, input logic [15:0] dd);
    rst  = r;
    cen  = ce;
    oc_n = oc;
    c    = cc;
    d    = dd;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  // Output seen now is the state logged DLY_CYC cen edges after the sample edge
  task automatic checkOutput();
    logic [8:0]  e;
    logic [15:0] expQ;
    logic [1:0]  expD;
    for (int i = 0; i < NDUT; i++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (m_count[i] >= unsigned'(dlyOf(i) + 1))
          e = m_hist[i][ch][(m_count[i] - unsigned'(dlyOf(i))) % 32];
        else
          e = 9'h000;
        expD[ch]          = e[8];
        expQ[ch*8 +: 8]   = e[8] ? e[7:0] : 8'hFF;
      end
      compare($sformatf("model q dut%0d", i), qa[i], expQ);
      compare($sformatf("model q_drive dut%0d", i), {14'h0, da[i]}, {14'h0, expD});
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst = 1'b1; cen = 1'b1; oc_n = 2'b11; c = 2'b11; d = 16'hFFFF;

    // Reset with c and d high: float pattern, nothing driven
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b11, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, 2'b11, 2'b11, 16'hFFFF);
    for (int i = 0; i < NDUT; i++) begin
      compare($sformatf("reset q dut%0d", i), qa[i], 16'hFFFF);
      compare($sformatf("reset q_drive dut%0d", i), {14'h0, da[i]}, 16'h0000);
    end

    // Release with c held high: 373 captures, 374 must not
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 2'b00, 2'b11, 16'h1234);
    compare("latch follows d", qa[0], 16'h1234);
    compare("edge no capture on release", qa[1], 16'h0000);
    compare("edge drive after release", {14'h0, da[1]}, 16'h0003);
    compare("dly0 no capture on release", qa[2], 16'h0000);

    // Transparent latch: A5 held after c falls, 3C never shown
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b01, 16'h00A5);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 16'h003C);
    compare("A5 not yet visible", qa[0], 16'h1234);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 16'h003C);
    compare("A5 at third edge", qa[0], 16'h12A5);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 16'h003C);
    compare("A5 holds", qa[0], 16'h12A5);

    // Edge register: 5A captured on rising c1, ignored while c1 stays high
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b10, 16'h5A00);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 2'b00, 2'b10, 16'hFF00);
    compare("5A held while c high", {8'h00, qa[1][15:8]}, 16'h005A);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 16'h0F00);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b10, 16'h0F00);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 2'b00, 2'b10, 16'h0000);
    compare("0F on next rising edge", {8'h00, qa[1][15:8]}, 16'h000F);

    // Disable channel 0 on the same edge its data change: both land together
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b01, 16'h0077);
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b00, 16'h0077);
    compare("still driven before disable", {14'h0, da[0]}, 16'h0003);
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b00, 16'h0077);
    compare("disable reaches output", {14'h0, da[0]}, 16'h0002);
    compare("disabled byte floats", {8'h00, qa[0][7:0]}, 16'h00FF);

    // Reset in flight: C3 captured then discarded
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 16'h0000);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b10, 16'hC300);
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b10, 16'h0000);
    compare("mid-flight reset q", qa[1], 16'hFFFF);
    compare("mid-flight reset drive", {14'h0, da[1]}, 16'h0000);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 2'b00, 2'b10, 16'h0000);
    compare("C3 discarded", qa[1], 16'h0000);

    // Randomised traffic with cen gaps and occasional reset
    for (int k = 0; k < 3000; k++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 3) != 0,
                    {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
                    2'($urandom),
                    16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
